// File: rtl/ssid_request_queue.sv
// ---------------------------------------------------------------------------
// ssid_request_queue
//
// Request buffer in front of the HNM bitmap stage. SSID write requests (hit
// marking) and read requests (hit lookup) are queued in two independent
// circular FIFOs. A small phase FSM drains them onto the HNM's single SSID
// port as registered one-cycle strobes. Writes have priority. After the last
// write, a gap of WR_TO_RD_GAP idle cycles is enforced before any read, so a
// lookup can never overtake a BRAM write that is still in flight.
//
// Parameters:
//   SSIDBITS      SSID width (row + column bits)
//   FIFO_DEPTH    entries per FIFO, power of 2, >= 2
//   WR_TO_RD_GAP  idle cycles after the last write before a read, >= 1
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   clear              synchronous flush of both FIFOs and the FSM
//   wr_valid/wr_ssid   push into the write FIFO; wr_full = FIFO holds DEPTH
//   rd_valid/rd_ssid   push into the read FIFO;  rd_full = FIFO holds DEPTH
//   hnm_write_ready    HNM accepts a write this cycle
//   hnm_read_ready     HNM accepts a read this cycle
//   hnm_ssid           SSID presented to the HNM (held between strobes)
//   hnm_write/hnm_read one-cycle strobes, never high together
//   busy               a FIFO is non-empty, or the FSM is counting the gap
//
// Optional feature (macro SSID_QUEUE_DROP_COUNT_EN):
//   wr_drop_count/rd_drop_count  16-bit saturating counts of pushes that were
//   dropped because the FIFO was full. Reset and clear zero them.
// ---------------------------------------------------------------------------
module ssid_request_queue #(
    parameter int SSIDBITS     = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int WR_TO_RD_GAP = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                wr_valid,
    input  logic [SSIDBITS-1:0] wr_ssid,
    output logic                wr_full,
    input  logic                rd_valid,
    input  logic [SSIDBITS-1:0] rd_ssid,
    output logic                rd_full,
    input  logic                hnm_write_ready,
    input  logic                hnm_read_ready,
    output logic [SSIDBITS-1:0] hnm_ssid,
    output logic                hnm_write,
    output logic                hnm_read,
    output logic                busy
`ifdef SSID_QUEUE_DROP_COUNT_EN
    ,
    output logic [15:0]         wr_drop_count,
    output logic [15:0]         rd_drop_count
`endif
);

    localparam int ADDRBITS = $clog2(FIFO_DEPTH);
    localparam int PTRBITS  = ADDRBITS + 1;
    localparam int GAPBITS  = $clog2(WR_TO_RD_GAP) + 1;

    localparam logic [PTRBITS-1:0] FULLCOUNT = PTRBITS'(FIFO_DEPTH);
    localparam logic [GAPBITS-1:0] GAPLAST   = GAPBITS'(WR_TO_RD_GAP - 1);

    typedef enum logic [1:0] {
        WRITE_PHASE = 2'd0,
        GAP         = 2'd1,
        READ_PHASE  = 2'd2
    } phaseType;

    // -----------------------------------------------------------------------
    // FIFO storage and pointers. Pointers carry one extra bit so a full FIFO
    // (occupancy == FIFO_DEPTH) is distinguishable from an empty one.
    // -----------------------------------------------------------------------
    logic [SSIDBITS-1:0] wrMem [FIFO_DEPTH];
    logic [SSIDBITS-1:0] rdMem [FIFO_DEPTH];

    logic [PTRBITS-1:0] wrHeadPtr, wrTailPtr;
    logic [PTRBITS-1:0] rdHeadPtr, rdTailPtr;
    logic [PTRBITS-1:0] wrOccupancy, rdOccupancy;

    logic wrEmpty, rdEmpty;
    logic wrPush, rdPush;
    logic wrPop, rdPop;

    phaseType           phase;
    logic [GAPBITS-1:0] gapCount;

    assign wrOccupancy = wrTailPtr - wrHeadPtr;
    assign rdOccupancy = rdTailPtr - rdHeadPtr;
    assign wrEmpty     = (wrOccupancy == '0);
    assign rdEmpty     = (rdOccupancy == '0);
    assign wr_full     = (wrOccupancy == FULLCOUNT);
    assign rd_full     = (rdOccupancy == FULLCOUNT);

    // A push into a full FIFO is dropped even if a pop frees a slot in the
    // same cycle; clear discards pushes outright.
    assign wrPush = wr_valid && !wr_full && !clear;
    assign rdPush = rd_valid && !rd_full && !clear;

    assign busy = !wrEmpty || !rdEmpty || (phase == GAP);

    // -----------------------------------------------------------------------
    // Issue decision. Writes may leave from WRITE_PHASE or straight from an
    // idle READ_PHASE; a read only leaves READ_PHASE with no write queued.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        wrPop = 1'b0;
        rdPop = 1'b0;
        if (!clear) begin
            if (phase == WRITE_PHASE || phase == READ_PHASE) begin
                wrPop = !wrEmpty && hnm_write_ready;
            end
            if (phase == READ_PHASE && wrEmpty) begin
                rdPop = !rdEmpty && hnm_read_ready;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pointer update.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state always uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            wrHeadPtr <= '0;
            wrTailPtr <= '0;
            rdHeadPtr <= '0;
            rdTailPtr <= '0;
        end else if (clear) begin
            wrHeadPtr <= '0;
            wrTailPtr <= '0;
            rdHeadPtr <= '0;
            rdTailPtr <= '0;
        end else begin
            if (wrPush) wrTailPtr <= wrTailPtr + 1'b1;
            if (wrPop)  wrHeadPtr <= wrHeadPtr + 1'b1;
            if (rdPush) rdTailPtr <= rdTailPtr + 1'b1;
            if (rdPop)  rdHeadPtr <= rdHeadPtr + 1'b1;
        end
    end

    // NOTE: the storage arrays have no reset; the pointers alone decide which
    // entries are valid, which keeps the arrays mappable onto RAM.
    always_ff @(posedge clk) begin
        if (wrPush) wrMem[wrTailPtr[ADDRBITS-1:0]] <= wr_ssid;
        if (rdPush) rdMem[rdTailPtr[ADDRBITS-1:0]] <= rd_ssid;
    end

    // -----------------------------------------------------------------------
    // Phase FSM with registered strobes and SSID.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= WRITE_PHASE;
            gapCount  <= '0;
            hnm_write <= 1'b0;
            hnm_read  <= 1'b0;
            hnm_ssid  <= '0;
        end else begin
            hnm_write <= wrPop;
            hnm_read  <= rdPop;
            if (wrPop) begin
                hnm_ssid <= wrMem[wrHeadPtr[ADDRBITS-1:0]];
            end else if (rdPop) begin
                hnm_ssid <= rdMem[rdHeadPtr[ADDRBITS-1:0]];
            end

            if (clear) begin
                phase    <= WRITE_PHASE;
                gapCount <= '0;
            end else begin
                case (phase)
                    WRITE_PHASE: begin
                        if (wrEmpty) begin
                            phase    <= GAP;
                            gapCount <= '0;
                        end
                    end
                    GAP: begin
                        // A fresh write cancels the gap; it restarts from zero
                        // once that write has drained.
                        if (!wrEmpty) begin
                            phase <= WRITE_PHASE;
                        end else if (gapCount == GAPLAST) begin
                            phase    <= READ_PHASE;
                            gapCount <= '0;
                        end else begin
                            gapCount <= gapCount + 1'b1;
                        end
                    end
                    READ_PHASE: begin
                        if (!wrEmpty) phase <= WRITE_PHASE;
                    end
                    default: begin
                        phase    <= WRITE_PHASE;
                        gapCount <= '0;
                    end
                endcase
            end
        end
    end

`ifdef SSID_QUEUE_DROP_COUNT_EN
    // -----------------------------------------------------------------------
    // Saturating drop counters.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_drop_count <= '0;
            rd_drop_count <= '0;
        end else if (clear) begin
            wr_drop_count <= '0;
            rd_drop_count <= '0;
        end else begin
            if (wr_valid && wr_full && wr_drop_count != 16'hFFFF) begin
                wr_drop_count <= wr_drop_count + 16'd1;
            end
            if (rd_valid && rd_full && rd_drop_count != 16'hFFFF) begin
                rd_drop_count <= rd_drop_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ssid_request_queue.sv
// ---------------------------------------------------------------------------
// tb_ssid_request_queue
//
// Directed bench for ssid_request_queue. Expected SSIDs are queued when a push
// is driven and popped by a negedge monitor whenever the DUT strobes. The
// monitor also checks strobe exclusivity, write-before-read ordering and the
// write-to-read gap. Inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ssid_request_queue;

    localparam int SSIDBITS     = 16;
    localparam int FIFO_DEPTH   = 16;
    localparam int WR_TO_RD_GAP = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                clear;
    logic                wr_valid;
    logic [SSIDBITS-1:0] wr_ssid;
    logic                wr_full;
    logic                rd_valid;
    logic [SSIDBITS-1:0] rd_ssid;
    logic                rd_full;
    logic                hnm_write_ready;
    logic                hnm_read_ready;
    logic [SSIDBITS-1:0] hnm_ssid;
    logic                hnm_write;
    logic                hnm_read;
    logic                busy;
`ifdef SSID_QUEUE_DROP_COUNT_EN
    logic [15:0]         wr_drop_count;
    logic [15:0]         rd_drop_count;
`endif

    ssid_request_queue #(
        .SSIDBITS    (SSIDBITS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .WR_TO_RD_GAP(WR_TO_RD_GAP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .wr_valid       (wr_valid),
        .wr_ssid        (wr_ssid),
        .wr_full        (wr_full),
        .rd_valid       (rd_valid),
        .rd_ssid        (rd_ssid),
        .rd_full        (rd_full),
        .hnm_write_ready(hnm_write_ready),
        .hnm_read_ready (hnm_read_ready),
        .hnm_ssid       (hnm_ssid),
        .hnm_write      (hnm_write),
        .hnm_read       (hnm_read),
        .busy           (busy)
`ifdef SSID_QUEUE_DROP_COUNT_EN
        ,
        .wr_drop_count  (wr_drop_count),
        .rd_drop_count  (rd_drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int passes      = 0;
    int cycle       = 0;
    int lastWrCycle = -100;
    int wrStrobes   = 0;
    int rdStrobes   = 0;

    logic [SSIDBITS-1:0] expWr[$];
    logic [SSIDBITS-1:0] expRd[$];

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n = 0;
        while ((expWr.size() != 0 || expRd.size() != 0) && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 32'(expWr.size() == 0 && expRd.size() == 0), 32'd1);
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset && (hnm_write || hnm_read)) begin
            check("strobe_exclusive", 32'(hnm_write & hnm_read), 32'd0);
            if (hnm_write) begin
                wrStrobes   <= wrStrobes + 1;
                lastWrCycle <= cycle;
                check("wr_expected", 32'(expWr.size() != 0), 32'd1);
                if (expWr.size() != 0) check("wr_ssid_order", 32'(hnm_ssid), 32'(expWr.pop_front()));
            end else begin
                rdStrobes <= rdStrobes + 1;
                check("rd_expected", 32'(expRd.size() != 0), 32'd1);
                check("rd_no_pending_wr", 32'(expWr.size() == 0), 32'd1);
                check("rd_gap", 32'((cycle - lastWrCycle) > WR_TO_RD_GAP), 32'd1);
                if (expRd.size() != 0) check("rd_ssid_order", 32'(hnm_ssid), 32'(expRd.pop_front()));
            end
        end
    end

    int wrBase;
    int rdBase;

    initial begin
        reset           = 1'b1;
        clear           = 1'b0;
        wr_valid        = 1'b0;
        wr_ssid         = '0;
        rd_valid        = 1'b0;
        rd_ssid         = '0;
        hnm_write_ready = 1'b1;
        hnm_read_ready  = 1'b1;

        // Reset state.
        #12;
        check("rst_hnm_write", 32'(hnm_write), 32'd0);
        check("rst_hnm_read",  32'(hnm_read),  32'd0);
        check("rst_hnm_ssid",  32'(hnm_ssid),  32'd0);
        check("rst_wr_full",   32'(wr_full),   32'd0);
        check("rst_rd_full",   32'(rd_full),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(10);

        // Single write from idle: strobe 2 cycles after push, one cycle wide.
        wr_valid = 1'b1;
        wr_ssid  = 16'h0A05;
        expWr.push_back(16'h0A05);
        step(1);
        wr_valid = 1'b0;
        check("s1_write_c1", 32'(hnm_write), 32'd0);
        step(1);
        check("s1_write_c2", 32'(hnm_write), 32'd1);
        check("s1_ssid_c2",  32'(hnm_ssid),  32'h0A05);
        step(1);
        check("s1_write_c3", 32'(hnm_write), 32'd0);
        step(1);
        check("s1_busy_gap", 32'(busy), 32'd1);
        step(8);
        check("s1_busy_idle", 32'(busy), 32'd0);

        // Reset pulse between edges, then read then write pushes.
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step(1);
        rd_valid = 1'b1;
        rd_ssid  = 16'h0003;
        expRd.push_back(16'h0003);
        step(1);
        rd_valid = 1'b0;
        wr_valid = 1'b1;
        wr_ssid  = 16'h0102;
        expWr.push_back(16'h0102);
        step(1);
        wr_valid = 1'b0;
        waitDrain("s2_drain", 40);
        step(10);

        // Fill the write FIFO with ready low; 17th push and a push on the
        // release cycle are dropped.
        hnm_write_ready = 1'b0;
        wrBase = wrStrobes;
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1;
            wr_ssid  = 16'h1000 + 16'(i);
            if (i < FIFO_DEPTH) expWr.push_back(16'h1000 + 16'(i));
            if (i == 15) check("s3_not_full_15", 32'(wr_full), 32'd0);
            if (i == 16) check("s3_full_16", 32'(wr_full), 32'd1);
            step(1);
        end
`ifdef SSID_QUEUE_DROP_COUNT_EN
        check("s3_drop_1", 32'(wr_drop_count), 32'd1);
`endif
        hnm_write_ready = 1'b1;
        wr_ssid         = 16'hBEEF;
        step(1);
        wr_valid = 1'b0;
`ifdef SSID_QUEUE_DROP_COUNT_EN
        check("s3_drop_2", 32'(wr_drop_count), 32'd2);
`endif
        waitDrain("s3_drain", 60);
        step(10);
        check("s3_write_count", 32'(wrStrobes - wrBase), 32'd16);
        check("s3_full_clear", 32'(wr_full), 32'd0);

        // Write during GAP restarts the gap ahead of the pending read.
        wr_valid = 1'b1;
        wr_ssid  = 16'h0011;
        rd_valid = 1'b1;
        rd_ssid  = 16'h0022;
        expWr.push_back(16'h0011);
        expRd.push_back(16'h0022);
        step(1);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        step(3);
        check("s4_busy_gap", 32'(busy), 32'd1);
        wr_valid = 1'b1;
        wr_ssid  = 16'h00FF;
        expWr.push_back(16'h00FF);
        step(1);
        wr_valid = 1'b0;
        waitDrain("s4_drain", 40);
        step(10);

        // Clear with queued entries and a simultaneous push.
        hnm_write_ready = 1'b0;
        hnm_read_ready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_ssid  = 16'h0501 + 16'(i);
            rd_valid = (i < 3);
            rd_ssid  = 16'h0581 + 16'(i);
            step(1);
        end
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        clear    = 1'b1;
        step(1);
        clear    = 1'b0;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        check("s5_busy",    32'(busy),    32'd0);
        check("s5_wr_full", 32'(wr_full), 32'd0);
        check("s5_rd_full", 32'(rd_full), 32'd0);
`ifdef SSID_QUEUE_DROP_COUNT_EN
        check("s5_drop_clr", 32'(wr_drop_count), 32'd0);
`endif
        wrBase          = wrStrobes;
        rdBase          = rdStrobes;
        hnm_write_ready = 1'b1;
        hnm_read_ready  = 1'b1;
        step(20);
        check("s5_no_strobes", 32'((wrStrobes - wrBase) + (rdStrobes - rdBase)), 32'd0);

        // Asynchronous reset in the middle of a read burst.
        for (int i = 0; i < 12; i++) begin
            rd_valid = (i < 4);
            rd_ssid  = 16'h0601 + 16'(i);
            if (i < 4) expRd.push_back(16'h0601 + 16'(i));
            step(1);
            if (i >= 3 && hnm_read) break;
        end
        rd_valid = 1'b0;
        check("s6_burst_seen", 32'(hnm_read), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("s6_rst_read",    32'(hnm_read),  32'd0);
        check("s6_rst_busy",    32'(busy),      32'd0);
        check("s6_rst_wr_full", 32'(wr_full),   32'd0);
        check("s6_rst_rd_full", 32'(rd_full),   32'd0);
        check("s6_rst_ssid",    32'(hnm_ssid),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        expWr.delete();
        expRd.delete();
        wrBase = wrStrobes;
        rdBase = rdStrobes;
        step(10);
        check("s6_no_strobes", 32'((wrStrobes - wrBase) + (rdStrobes - rdBase)), 32'd0);
        wr_valid = 1'b1;
        wr_ssid  = 16'h0777;
        expWr.push_back(16'h0777);
        step(1);
        wr_valid = 1'b0;
        waitDrain("s6_drain", 40);
        check("s6_one_write", 32'(wrStrobes - wrBase), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
